// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_IMMEX   = 4'd8,
    S_IMMWB   = 4'd9,
    S_BEQEX   = 4'd10,
    S_BNEEX   = 4'd11,
    S_JEX     = 4'd12,
    S_JALEX   = 4'd13,
    S_ERR     = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE = 3'd0,
    CL_LW    = 3'd1,
    CL_SW    = 3'd2,
    CL_BEQ   = 3'd3,
    CL_BNE   = 3'd4,
    CL_J     = 3'd5,
    CL_JAL   = 3'd6,
    CL_IMM   = 3'd7
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_LUI   = 4'd7;
  localparam logic [3:0] ALU_FUNCT = 4'd15;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Where a memory-wait state goes once mem_ready arrives.
  function automatic state_t wait_done_next(input state_t s);
    case (s)
      S_FETCH: return S_DECODE;
      S_MEMRD: return S_MEMWB;
      default: return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_maindec_op_classify.sv
// Opcode classifier shared by DECODE dispatch and the IMMEX output decode.
module op_classify
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output iclass_t    iclass,
  output logic [3:0] imm_aluop,
  output logic       imm_zeroextend,
  output logic       legal
);

  // Pure lookup from opcode to instruction class and immediate-op ALU control.
  always_comb begin
    iclass         = CL_RTYPE;
    imm_aluop      = ALU_ADD;
    imm_zeroextend = 1'b0;
    legal          = 1'b1;
    case (op)
      OP_RTYPE: iclass = CL_RTYPE;
      OP_LW:    iclass = CL_LW;
      OP_SW:    iclass = CL_SW;
      OP_BEQ:   iclass = CL_BEQ;
      OP_BNE:   iclass = CL_BNE;
      OP_J:     iclass = CL_J;
      OP_JAL:   iclass = CL_JAL;
      OP_ADDI, OP_ADDIU: iclass = CL_IMM;
      OP_SLTI:  begin iclass = CL_IMM; imm_aluop = ALU_SLT;  end
      OP_SLTIU: begin iclass = CL_IMM; imm_aluop = ALU_SLTU; end
      OP_ANDI:  begin iclass = CL_IMM; imm_aluop = ALU_AND; imm_zeroextend = 1'b1; end
      OP_ORI:   begin iclass = CL_IMM; imm_aluop = ALU_OR;  imm_zeroextend = 1'b1; end
      OP_XORI:  begin iclass = CL_IMM; imm_aluop = ALU_XOR; imm_zeroextend = 1'b1; end
      OP_LUI:   begin iclass = CL_IMM; imm_aluop = ALU_LUI; imm_zeroextend = 1'b1; end
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main control FSM: sequences fetch/decode/execute/writeback,
// waits on the shared memory with a bounded timeout, flags illegal opcodes.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction; PC/IR update when mem_ready
// DECODE    | dispatch on opcode, precompute branch target
// MEMADR    | compute load/store address
// MEMRD     | load read, wait for mem_ready
// MEMWB     | write load data to register file
// MEMWR     | store write, wait for mem_ready
// RTYPEEX   | ALU operation per funct
// RTYPEWB   | write ALU result to rd
// IMMEX     | ALU operation with immediate
// IMMWB     | write ALU result to rt
// BEQEX     | compare, PC update if zero
// BNEEX     | compare, PC update if not zero
// JEX       | jump
// JALEX     | jump and link to r31
// ERR       | illegal opcode or memory timeout; held until reset
module mc_maindec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               branch_ne,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               link,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               zeroextend,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic               mem_timeout,
  output logic [3:0]         state_o
);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  iclass_t         iclass;
  logic [3:0]      imm_aluop;
  logic            imm_ze;
  logic            legal;
  logic [3:0]      alu4;
  logic            pcwrite_s, branch_s, branch_ne_s, memread_s, memwrite_s;
  logic            irwrite_s, regwrite_s, link_s;
  logic            wait_hit;

  op_classify u_op_classify (
    .op             (op),
    .iclass         (iclass),
    .imm_aluop      (imm_aluop),
    .imm_zeroextend (imm_ze),
    .legal          (legal)
  );

  // This wait cycle would be the MEM_TIMEOUT-th consecutive one without mem_ready.
  assign wait_hit = (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

  // State sequencing, memory wait counter and sticky error flags.
  // The counter is cleared on every state change, so it is zero on entry to
  // each of the three memory-wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            state    <= wait_done_next(state);
            wait_cnt <= '0;
          end else if (wait_hit) begin
            state       <= S_ERR;
            wait_cnt    <= '0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          if (!legal) begin
            state   <= S_ERR;
            illegal <= 1'b1;
          end else begin
            case (iclass)
              CL_RTYPE:     state <= S_RTYPEEX;
              CL_LW, CL_SW: state <= S_MEMADR;
              CL_BEQ:       state <= S_BEQEX;
              CL_BNE:       state <= S_BNEEX;
              CL_J:         state <= S_JEX;
              CL_JAL:       state <= S_JALEX;
              default:      state <= S_IMMEX;
            endcase
          end
        end
        S_MEMADR:  state <= (iclass == CL_SW) ? S_MEMWR : S_MEMRD;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_IMMEX:   state <= S_IMMWB;
        S_ERR:     state <= S_ERR;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; only FETCH looks at mem_ready for the PC/IR load.
  always_comb begin
    pcwrite_s   = 1'b0;
    branch_s    = 1'b0;
    branch_ne_s = 1'b0;
    memread_s   = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    link_s      = 1'b0;
    iord        = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_RT;
    pcsrc       = PCSRC_ALU;
    zeroextend  = 1'b0;
    alu4        = ALU_ADD;
    case (state)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb   = SRCB_FOUR;
        pcwrite_s = mem_ready;
        irwrite_s = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        memread_s = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alu4    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alu4       = imm_aluop;
        zeroextend = imm_ze;
      end
      S_IMMWB: regwrite_s = 1'b1;
      S_BEQEX, S_BNEEX: begin
        alusrca     = 1'b1;
        alu4        = ALU_SUB;
        pcsrc       = PCSRC_ALUOUT;
        branch_s    = (state == S_BEQEX);
        branch_ne_s = (state == S_BNEEX);
      end
      S_JEX, S_JALEX: begin
        pcwrite_s  = 1'b1;
        pcsrc      = PCSRC_JUMP;
        regwrite_s = (state == S_JALEX);
        link_s     = (state == S_JALEX);
      end
      default: ;
    endcase
  end

  // Enables are suppressed for the whole reset cycle, whatever the state.
  assign pcwrite   = pcwrite_s   & ~reset;
  assign branch    = branch_s    & ~reset;
  assign branch_ne = branch_ne_s & ~reset;
  assign memread   = memread_s   & ~reset;
  assign memwrite  = memwrite_s  & ~reset;
  assign irwrite   = irwrite_s   & ~reset;
  assign regwrite  = regwrite_s  & ~reset;
  assign link      = link_s      & ~reset;

  assign aluop   = ALUOP_W'(alu4);
  assign state_o = state;

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle main control FSM; successor to the single-cycle opcode decoder.
- Sequences FETCH/DECODE/execute/writeback per instruction and drives datapath enables each cycle.
- Waits on a shared instruction/data memory through a ready handshake, with a timeout.
- Parametrised ALU-op width; adds BNE, SLTIU and JAL; flags illegal opcodes instead of emitting X.

Parameters:
- ALUOP_W, 4: aluop width; must be >= 4; upper bits are driven 0.
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready before the error state; must be >= 1.
- TO_W, $clog2(MEM_TIMEOUT+1): wait counter width; derived, do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op  in  6  instruction opcode, from the instruction register.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pcwrite  out  1  unconditional PC update.
- branch  out  1  PC update if zero.
- branch_ne  out  1  PC update if not zero.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load.
- regdst  out  1  write-register select: rd (1) or rt (0).
- memtoreg  out  1  writeback data from memory.
- regwrite  out  1  register file write.
- link  out  1  write PC+4 to register 31.
- alusrca  out  1  ALU A operand: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- zeroextend  out  1  zero-extend the immediate.
- aluop  out  ALUOP_W  0 = add, 1 = sub, 2 = slt, 3 = sltu, 4 = and, 5 = or, 6 = xor, 7 = lui, 15 = use funct.
- illegal  out  1  sticky: unknown opcode was decoded.
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT.
- state_o  out  4  current state, for debug.

Behaviour:
- Single clock clk; reset is synchronous and active-high. Reset sets state = FETCH, wait counter = 0, illegal = 0, mem_timeout = 0.
- While reset = 1, all enables are forced to 0: pcwrite, irwrite, regwrite, memwrite, memread, branch, branch_ne, link.
- Outputs are Moore, decoded from state only. Exception: pcwrite and irwrite in FETCH are ANDed with mem_ready.
- Unlisted outputs are 0 in every state.
- States and transitions:
  - FETCH: memread = 1, alusrcb = 01, aluop = add. Hold until mem_ready = 1, then go to DECODE (pcwrite = irwrite = 1 in that cycle).
  - DECODE: alusrcb = 11, aluop = add. Dispatch on op:
    - 000000 -> RTYPEEX
    - 100011 and 101011 -> MEMADR
    - 000100 -> BEQEX
    - 000101 -> BNEEX
    - 000010 -> JEX
    - 000011 -> JALEX
    - 001000 to 001111 -> IMMEX
    - anything else -> ERR, with illegal set.
  - MEMADR: alusrca = 1, alusrcb = 10, aluop = add. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD: iord = 1, memread = 1. Hold until mem_ready, then MEMWB.
  - MEMWB: regwrite = 1, memtoreg = 1. Go to FETCH.
  - MEMWR: iord = 1, memwrite = 1. Hold until mem_ready, then FETCH.
  - RTYPEEX: alusrca = 1, aluop = 15. Go to RTYPEWB.
  - RTYPEWB: regdst = 1, regwrite = 1. Go to FETCH.
  - IMMEX: alusrca = 1, alusrcb = 10. aluop and zeroextend per opcode:
    - ADDI, ADDIU: add
    - SLTI: slt
    - SLTIU: sltu
    - ANDI, ORI, XORI, LUI: and, or, xor, lui, each with zeroextend = 1.
    - Go to IMMWB.
  - IMMWB: regwrite = 1. Go to FETCH.
  - BEQEX / BNEEX: alusrca = 1, aluop = sub, pcsrc = 01, branch (BEQEX) or branch_ne (BNEEX) = 1. Go to FETCH.
  - JEX: pcwrite = 1, pcsrc = 10. Go to FETCH.
  - JALEX: as JEX, plus regwrite = 1 and link = 1. Go to FETCH.
  - ERR: absorbing; all enables 0 until reset.
- Latencies with zero memory wait:
  - 3 cycles: BEQ, BNE, J, JAL
  - 4 cycles: R-type, immediate ops, SW
  - 5 cycles: LW
  - Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR.
  - Increments on each cycle in those states with mem_ready = 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, go to ERR and set mem_timeout.
  - mem_ready = 1 on the cycle the count reaches MEM_TIMEOUT wins: normal transition, no error.
- Reset mid-instruction (including during a wait, or in ERR): next state is FETCH and no write enable pulses in the reset cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI to OP_LUI
  - ALU-op constants (4-bit, zero-extended to ALUOP_W)
  - alusrcb and pcsrc encodings
- One combinational sub-module, op_classify: op -> {instr class, imm aluop, zeroextend, legal}. It is reused by DECODE dispatch and the IMMEX outputs.

Test Plan:
- ADD (op = 000000), mem_ready tied 1 -> states FETCH, DECODE, RTYPEEX, RTYPEWB; regwrite = regdst = 1 in cycle 4 only; aluop = 15 in cycle 3.
- LW (op = 100011), mem_ready low 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total; irwrite pulses once; memtoreg = regwrite = 1 in MEMWB.
- BNE (op = 000101) then JAL (op = 000011) -> BNEEX asserts branch_ne = 1, pcsrc = 01, aluop = 1; JALEX asserts pcwrite = link = regwrite = 1, pcsrc = 10; each takes 3 cycles.
- ORI (op = 001101) and SLTIU (op = 001011) -> IMMEX aluop = 5 with zeroextend = 1; aluop = 3 with zeroextend = 0.
- op = 111111 -> ERR after DECODE, illegal = 1 and held; all enables 0 for 20 cycles; reset -> FETCH, illegal = 0.
- SW with mem_ready held 0 and MEM_TIMEOUT = 15 -> mem_timeout = 1 after 15 wait cycles in MEMWR. Repeat with mem_ready = 1 on the 15th wait cycle -> no error, state returns to FETCH.
